fib_seq_gen_nb: RTL and testbench
=================================

// Module: fib_seq_gen_nb
// PURPOSE
//  Parametrised Fibonacci/Lucas sequence engine: on START, generates DEPTH terms of
//  W-bit width into internal single-port RAM, one term per CLK, then enters playback.
//  Playback steps the read address on an external STEP tick (e.g. slow-clock enable).
//  Sits between button/clock-divider logic and univ_sseg; DATA_OUT feeds the display.
//  Adds sequence-mode select, overflow saturation and a BUSY/DONE handshake.
// PARAMETERS
//  W      11   term width in bits
//  AW     4    address width; DEPTH = 2**AW terms generated per run
// PORTS
//  CLK       in   1   system clock; all state changes on rising edge
//  RST       in   1   asynchronous, active-high reset
//  START     in   1   one-cycle pulse; begins a generation run (synchronous)
//  MODE      in   1   0 = Fibonacci (seeds 0,1); 1 = Lucas (seeds 2,1); sampled on START only
//  STEP      in   1   playback advance enable (one-CLK pulse per step)
//  BUSY      out  1   1 while in GEN
//  DONE      out  1   one-cycle pulse after the last term is written
//  OVF       out  1   sticky; set when any term saturated in the current run
//  ADDR      out  AW  current playback read address
//  DATA_OUT  out  W   mem[ADDR], registered
// BEHAVIOUR
//  - RST: state=IDLE; BUSY, DONE, OVF, ADDR, DATA_OUT = 0; term regs a,b = 0; RAM not cleared.
//  - States: IDLE, GEN, PLAY. Encoding 2-bit binary.
//  - IDLE: START -> GEN; wr_addr<=0; a<=seed0(MODE); b<=seed1(MODE); OVF<=0.
//  - GEN: each cycle mem[wr_addr]<=a; a<=b; b<=next; wr_addr++.
//    next = (a+b computed W+1 bits); if sum[W]==1 or b==all-ones-from-saturation,
//    next = {W{1'b1}} and OVF<=1 (sticky until next START). Seeds never overflow.
//  - Write at wr_addr==DEPTH-1 is the final write; next cycle state=PLAY, DONE=1
//    for exactly that cycle, ADDR<=0.
//  - START during GEN is ignored; MODE changes during GEN have no effect.
//  - PLAY: STEP -> ADDR<=ADDR+1, wraps DEPTH-1 -> 0. DATA_OUT updates 1 CLK after
//    ADDR changes (sync RAM read latency 1). START in PLAY -> GEN (restart, same as IDLE).
//  - START and STEP in same PLAY cycle: START wins, STEP dropped.
//  - IDLE: DATA_OUT tracks mem[ADDR] (stale data from prior run or X-free 0 after reset
//    in sim only if RAM initialised); STEP ignored in IDLE.
//  - RST asserted mid-GEN: immediate return to IDLE; partially written RAM contents are
//    undefined to consumers; DONE not pulsed.
//  - Run length fixed: exactly DEPTH writes, DEPTH+1 cycles START-to-DONE.
// STRUCTURE
//  - Shared package/header fib_defs: state localparams (S_IDLE, S_GEN, S_PLAY),
//    FIB_SEED0=0, FIB_SEED1=1, LUC_SEED0=2, LUC_SEED1=1.
//  - One sub-module: existing ram_single_port (n=AW, m=W), addr muxed wr_addr in GEN,
//    ADDR otherwise; we = (state==GEN).
//  - Everything else (FSM, term regs, saturating adder, address counters) in this file.
// TESTING (W=8, AW=4 unless stated)
//  1 RST mid-run: START, RST after 5 cycles -> IDLE, BUSY=0, DONE never pulses, OVF=0.
//  2 MODE=0, START -> BUSY 16 cycles, DONE pulse at cycle 17; step through: addr 0..13 =
//    0,1,1,2,3,5,8,13,21,34,55,89,144,233; addr 14,15 = 255; OVF=1.
//  3 MODE=1, START -> addr 0..11 = 2,1,3,4,7,11,18,29,47,76,123,199; addr 12..15 = 255;
//    OVF=1 from the addr-12 write onward.
//  4 W=11 default, MODE=0 -> addr 15 = 610, OVF=0 throughout.
//  5 PLAY wrap: 16 STEP pulses from ADDR=0 -> ADDR=0, DATA_OUT=mem[0] one cycle later;
//    START+STEP same cycle -> GEN entered, ADDR unchanged.
//  6 START pulses during GEN -> ignored; DONE still exactly once, 16 cycles after start.

Source files
------------

// File: rtl/fib_seq_gen_nb_pkg.sv
// rtl/fib_seq_gen_nb_pkg.sv - shared states and seed values for the Fibonacci/Lucas engine
package fib_seq_gen_nb_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GEN  = 2'd1,
        S_PLAY = 2'd2
    } state_t;

    localparam int FIB_SEED0 = 0;
    localparam int FIB_SEED1 = 1;
    localparam int LUC_SEED0 = 2;
    localparam int LUC_SEED1 = 1;

    function automatic int seed0(input logic mode);
        return mode ? LUC_SEED0 : FIB_SEED0;
    endfunction

    function automatic int seed1(input logic mode);
        return mode ? LUC_SEED1 : FIB_SEED1;
    endfunction

endpackage

// File: rtl/fib_seq_gen_nb_ram.sv
// rtl/fib_seq_gen_nb_ram.sv - single-port RAM with registered read (latency 1)
module fib_seq_gen_nb_ram #(
    parameter int N = 4,
    parameter int M = 11
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_we,
    input  logic [N-1:0] i_addr,
    input  logic [M-1:0] i_wdata,
    output logic [M-1:0] o_rdata
);

    logic [M-1:0] r_mem [2**N];
    logic [M-1:0] r_rdata;

    // Array itself is never reset; only the read register is.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/fib_seq_gen_nb.sv
// rtl/fib_seq_gen_nb.sv - Fibonacci/Lucas generator: fills RAM with 2**AW saturating terms, then plays back
module fib_seq_gen_nb
    import fib_seq_gen_nb_pkg::*;
#(
    parameter int W  = 11,
    parameter int AW = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic          i_mode,
    input  logic          i_step,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_ovf,
    output logic [AW-1:0] o_addr,
    output logic [W-1:0]  o_data_out
);

    state_t        r_state;
    logic          r_busy;
    logic          r_done;
    logic          r_ovf;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_wr_addr;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic          r_a_sat;
    logic          r_b_sat;

    logic [W:0]    w_sum;
    logic          w_sat;
    logic [W-1:0]  w_next;
    logic          w_we;
    logic [AW-1:0] w_ram_addr;

    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_sat  = w_sum[W] | r_b_sat;
    assign w_next = w_sat ? {W{1'b1}} : w_sum[W-1:0];

    // Each term carries a saturation flag so OVF rises when a clipped term is stored.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_addr    <= '0;
            r_wr_addr <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_a_sat   <= 1'b0;
            r_b_sat   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start && (r_state != S_GEN)) begin
                r_state   <= S_GEN;
                r_busy    <= 1'b1;
                r_wr_addr <= '0;
                r_a       <= W'(seed0(i_mode));
                r_b       <= W'(seed1(i_mode));
                r_a_sat   <= 1'b0;
                r_b_sat   <= 1'b0;
                r_ovf     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_busy <= 1'b0;
                    end
                    S_GEN: begin
                        r_a       <= r_b;
                        r_a_sat   <= r_b_sat;
                        r_b       <= w_next;
                        r_b_sat   <= w_sat;
                        r_wr_addr <= r_wr_addr + 1'b1;
                        if (r_a_sat) begin
                            r_ovf <= 1'b1;
                        end
                        if (&r_wr_addr) begin
                            r_state <= S_PLAY;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_addr  <= '0;
                        end
                    end
                    S_PLAY: begin
                        if (i_step) begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign w_we       = (r_state == S_GEN);
    assign w_ram_addr = w_we ? r_wr_addr : r_addr;

    fib_seq_gen_nb_ram #(
        .N(AW),
        .M(W)
    ) u_ram (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_we   (w_we),
        .i_addr (w_ram_addr),
        .i_wdata(r_a),
        .o_rdata(o_data_out)
    );

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_ovf  = r_ovf;
    assign o_addr = r_addr;

endmodule

// File: tb/tb_fib_seq_gen_nb.sv
// tb/tb_fib_seq_gen_nb.sv - self-checking bench for fib_seq_gen_nb at W=8 and W=11
module tb_fib_seq_gen_nb;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic        step;
    logic        busy8, done8, ovf8;
    logic [3:0]  addr8;
    logic [7:0]  data8;
    logic        busy11, done11, ovf11;
    logic [3:0]  addr11;
    logic [10:0] data11;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit mode;
        int addr;
        int v8;
        int v11;
    } vec_t;

    vec_t tbl[10];

    always #5 clk = ~clk;

    fib_seq_gen_nb #(.W(8), .AW(4)) dut8 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_step(step),
        .o_busy(busy8), .o_done(done8), .o_ovf(ovf8), .o_addr(addr8), .o_data_out(data8)
    );

    fib_seq_gen_nb #(.W(11), .AW(4)) dut11 (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode), .i_step(step),
        .o_busy(busy11), .o_done(done11), .o_ovf(ovf11), .o_addr(addr11), .o_data_out(data11)
    );

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int term(input bit m, input int w, input int i);
        int p, q, mx, nx;
        p  = m ? 2 : 0;
        q  = 1;
        mx = (1 << w) - 1;
        if (i == 0) return p;
        for (int k = 2; k <= i; k++) begin
            nx = p + q;
            if (nx > mx) nx = mx;
            p = q;
            q = nx;
        end
        return q;
    endfunction

    function automatic bit ovf_of(input bit m, input int w);
        int p, q, mx, nx;
        bit o;
        p  = m ? 2 : 0;
        q  = 1;
        mx = (1 << w) - 1;
        o  = 1'b0;
        for (int k = 2; k <= 15; k++) begin
            nx = p + q;
            if (nx > mx) begin
                nx = mx;
                o  = 1'b1;
            end
            p = q;
            q = nx;
        end
        return o;
    endfunction

    task automatic gen_run(input bit m, input bit with_step, input bit inject);
        int bc, dc, da;
        logic [3:0] pre;
        bc  = 0;
        dc  = 0;
        da  = 0;
        pre = addr8;
        mode  = m;
        start = 1'b1;
        step  = with_step;
        cyc();
        start = 1'b0;
        step  = 1'b0;
        mode  = ~m;
        if (with_step) chk("start_beats_step_addr", addr8, pre);
        for (int k = 1; k <= 17; k++) begin
            if (k > 1) begin
                if (inject && (k == 4 || k == 9)) start = 1'b1;
                cyc();
                start = 1'b0;
            end
            if (busy8) bc++;
            if (done8) begin
                dc++;
                da = k;
            end
        end
        chk("busy_cycles", bc, 16);
        chk("done_count", dc, 1);
        chk("done_cycle", da, 17);
        chk("busy_after_done", busy8, 0);
        chk("ovf_w8", ovf8, ovf_of(m, 8));
        chk("ovf_w11", ovf11, ovf_of(m, 11));
    endtask

    task automatic playback(input bit m);
        int gap;
        cyc();
        for (int a = 0; a < 16; a++) begin
            chk("play_addr", addr8, a);
            chk("play_data_w8", data8, term(m, 8, a));
            chk("play_data_w11", data11, term(m, 11, a));
            for (int t = 0; t < 10; t++) begin
                if (tbl[t].mode == m && tbl[t].addr == a) begin
                    chk("table_w8", data8, tbl[t].v8);
                    chk("table_w11", data11, tbl[t].v11);
                end
            end
            if (a < 15) begin
                gap = $urandom_range(0, 2);
                repeat (gap) cyc();
                step = 1'b1;
                cyc();
                step = 1'b0;
                cyc();
            end
        end
        step = 1'b1;
        cyc();
        step = 1'b0;
        chk("wrap_addr", addr8, 0);
        chk("wrap_data_stale", data8, term(m, 8, 15));
        cyc();
        chk("wrap_data", data8, term(m, 8, 0));
    endtask

    initial begin
        bit rm;
        int dcount;

        tbl[0] = '{1'b0, 0, 0, 0};
        tbl[1] = '{1'b0, 7, 13, 13};
        tbl[2] = '{1'b0, 13, 233, 233};
        tbl[3] = '{1'b0, 14, 255, 377};
        tbl[4] = '{1'b0, 15, 255, 610};
        tbl[5] = '{1'b1, 0, 2, 2};
        tbl[6] = '{1'b1, 11, 199, 199};
        tbl[7] = '{1'b1, 12, 255, 322};
        tbl[8] = '{1'b1, 13, 255, 521};
        tbl[9] = '{1'b1, 15, 255, 1364};

        rst   = 1'b1;
        start = 1'b0;
        mode  = 1'b0;
        step  = 1'b0;
        repeat (2) cyc();
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_ovf", ovf8, 0);
        chk("rst_addr", addr8, 0);
        chk("rst_data", data8, 0);
        chk("rst_data_w11", data11, 0);
        rst = 1'b0;
        cyc();

        step = 1'b1;
        cyc();
        step = 1'b0;
        chk("idle_step_ignored", addr8, 0);

        gen_run(1'b0, 1'b0, 1'b0);
        playback(1'b0);

        gen_run(1'b1, 1'b0, 1'b1);
        playback(1'b1);

        repeat (3) begin
            step = 1'b1;
            cyc();
            step = 1'b0;
        end
        chk("pre_restart_addr", addr8, 3);
        gen_run(1'b0, 1'b1, 1'b0);
        playback(1'b0);

        for (int r = 0; r < 3; r++) begin
            rm = 1'($urandom_range(0, 1));
            gen_run(rm, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            playback(rm);
        end
        chk("addr_w11_match", addr11, addr8);

        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (4) cyc();
        chk("midrun_busy_before_rst", busy8, 1);
        rst = 1'b1;
        #1;
        chk("midrun_rst_busy", busy8, 0);
        chk("midrun_rst_done", done8, 0);
        chk("midrun_rst_ovf", ovf8, 0);
        chk("midrun_rst_addr", addr8, 0);
        cyc();
        rst = 1'b0;
        dcount = 0;
        for (int k = 0; k < 25; k++) begin
            cyc();
            if (done8 || busy8) dcount++;
        end
        chk("midrun_no_done", dcount, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
